// File: rtl/serial_adder_bm_if.sv
// Operand, mode and result bundle for the bit-serial adder/subtractor.
// The master side issues start/operands and the slave side returns the results.
interface serial_adder_bm_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             c;
   logic             ovf;

   modport master (
      output start, sub, a, b,
      input  busy, done, s, c, ovf
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, s, c, ovf
   );
endinterface

// File: rtl/serial_adder_bm.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop,
// time-shared over WIDTH bits, LSB first.
// Subtraction is a + ~b + 1, with the +1 entering as the initial carry.
// The result shifts in at the MSB of s, so after WIDTH steps it is LSB aligned.
module serial_adder_bm #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   serial_adder_bm_if.slave bus
);

   localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] ra_q, ra_d;
   logic [WIDTH-1:0] rb_q, rb_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             cy_q, cy_d;
   logic             c_q, c_d;
   logic             ovf_q, ovf_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sum_bit;
   logic             cy_out;
   logic             accept;

   function automatic logic maj3(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

   // Next-state, operand capture and one full-adder bit-step per RUN cycle.
   always_comb begin
      state_d = state_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      s_d     = s_q;
      cy_d    = cy_q;
      c_d     = c_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      sum_bit = ra_q[0] ^ rb_q[0] ^ cy_q;
      cy_out  = maj3(ra_q[0], rb_q[0], cy_q);
      accept  = bus.start && (state_q != RUN);

      case (state_q)
         RUN: begin
            cy_d = cy_out;
            ra_d = ra_q >> 1;
            rb_d = rb_q >> 1;
            s_d  = {sum_bit, s_q[WIDTH-1:1]};
            if (cnt_q == LAST_BIT) begin
               // MSB step: carry into and out of the sign bit give overflow.
               c_d     = cy_out;
               ovf_d   = cy_q ^ cy_out;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A start in RUN is ignored; in IDLE or DONE it loads a new operation.
      if (accept) begin
         state_d = RUN;
         ra_d    = bus.a;
         rb_d    = bus.sub ? ~bus.b : bus.b;
         cy_d    = bus.sub;
         cnt_d   = '0;
         s_d     = '0;
      end
   end

   // State and datapath registers; reset discards any partial result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ra_q    <= '0;
         rb_q    <= '0;
         s_q     <= '0;
         cy_q    <= 1'b0;
         c_q     <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         s_q     <= s_d;
         cy_q    <= cy_d;
         c_q     <= c_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.busy = (state_q == RUN);
   assign bus.done = (state_q == DONE);
   assign bus.s    = s_q;
   assign bus.c    = c_q;
   assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_bm.sv
// Directed bench for serial_adder_bm at WIDTH=8, plus WIDTH=2 (exhaustive)
// and WIDTH=16 (corner and random operands) instances sharing clk/rst.
module tb_serial_adder_bm;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   serial_adder_bm_if #(.WIDTH(8))  bus8 ();
   serial_adder_bm_if #(.WIDTH(2))  bus2 ();
   serial_adder_bm_if #(.WIDTH(16)) bus16 ();

   serial_adder_bm #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
   serial_adder_bm #(.WIDTH(2))  dut2  (.clk(clk), .rst(rst), .bus(bus2));
   serial_adder_bm #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one WIDTH=8 operation and wait (bounded) for done.
   // lat counts negedge samples after the accepting edge; bcnt counts busy samples.
   task automatic run_op8(input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                          output logic [7:0] os, output logic oc, output logic oovf,
                          output int lat, output int bcnt);
      @(negedge clk);
      bus8.start = 1'b1;
      bus8.a     = ia;
      bus8.b     = ib;
      bus8.sub   = isub;
      @(negedge clk);
      bus8.start = 1'b0;
      bus8.a     = 8'h5A;
      bus8.b     = 8'hA5;
      bus8.sub   = ~isub;
      lat  = 0;
      bcnt = 0;
      while (!bus8.done && lat < 40) begin
         if (bus8.busy) bcnt++;
         @(negedge clk);
         lat++;
      end
      os   = bus8.s;
      oc   = bus8.c;
      oovf = bus8.ovf;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus8.start = 1'b1;
      bus8.a = 8'hFF;
      bus8.b = 8'h01;
      bus8.sub = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (bus8.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus8.busy); end
      checks++; if (bus8.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus8.done); end
      checks++; if (bus8.s !== 8'h00) begin failures++; $display("FAIL reset_s got=%h want=00", bus8.s); end
      checks++; if (bus8.c !== 1'b0) begin failures++; $display("FAIL reset_c got=%b want=0", bus8.c); end
      checks++; if (bus8.ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", bus8.ovf); end
      rst = 1'b0;
      bus8.start = 1'b0;
      @(negedge clk);
      checks++; if (bus8.busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b want=0", bus8.busy); end
   endtask

   task automatic test_add_basic();
      logic [7:0] rs;
      logic       rc, rv;
      int         lat, bcnt;
      run_op8(8'hFF, 8'h01, 1'b0, rs, rc, rv, lat, bcnt);
      checks++; if (lat !== 8) begin failures++; $display("FAIL add_ff_latency got=%0d want=8", lat); end
      checks++; if (bcnt !== 8) begin failures++; $display("FAIL add_ff_busy_cycles got=%0d want=8", bcnt); end
      checks++; if (rs !== 8'h00) begin failures++; $display("FAIL add_ff_s got=%h want=00", rs); end
      checks++; if (rc !== 1'b1) begin failures++; $display("FAIL add_ff_c got=%b want=1", rc); end
      checks++; if (rv !== 1'b0) begin failures++; $display("FAIL add_ff_ovf got=%b want=0", rv); end
      @(negedge clk);
      checks++; if (bus8.done !== 1'b0) begin failures++; $display("FAIL add_ff_done_pulse got=%b want=0", bus8.done); end
      checks++; if (bus8.busy !== 1'b0) begin failures++; $display("FAIL add_ff_busy_after got=%b want=0", bus8.busy); end
      repeat (3) @(negedge clk);
      checks++; if (bus8.s !== 8'h00 || bus8.c !== 1'b1) begin failures++; $display("FAIL add_ff_hold got=%h/%b want=00/1", bus8.s, bus8.c); end
   endtask

   task automatic test_add_overflow();
      logic [7:0] rs;
      logic       rc, rv;
      int         lat, bcnt;
      run_op8(8'h7F, 8'h01, 1'b0, rs, rc, rv, lat, bcnt);
      checks++; if (rs !== 8'h80) begin failures++; $display("FAIL add_7f_s got=%h want=80", rs); end
      checks++; if (rc !== 1'b0) begin failures++; $display("FAIL add_7f_c got=%b want=0", rc); end
      checks++; if (rv !== 1'b1) begin failures++; $display("FAIL add_7f_ovf got=%b want=1", rv); end
      run_op8(8'h80, 8'h80, 1'b0, rs, rc, rv, lat, bcnt);
      checks++; if (rs !== 8'h00) begin failures++; $display("FAIL add_80_s got=%h want=00", rs); end
      checks++; if (rc !== 1'b1) begin failures++; $display("FAIL add_80_c got=%b want=1", rc); end
      checks++; if (rv !== 1'b1) begin failures++; $display("FAIL add_80_ovf got=%b want=1", rv); end
   endtask

   task automatic test_sub();
      logic [7:0] rs;
      logic       rc, rv;
      int         lat, bcnt;
      run_op8(8'h05, 8'h07, 1'b1, rs, rc, rv, lat, bcnt);
      checks++; if (lat !== 8) begin failures++; $display("FAIL sub_05_latency got=%0d want=8", lat); end
      checks++; if (rs !== 8'hFE) begin failures++; $display("FAIL sub_05_s got=%h want=fe", rs); end
      checks++; if (rc !== 1'b0) begin failures++; $display("FAIL sub_05_c got=%b want=0", rc); end
      checks++; if (rv !== 1'b0) begin failures++; $display("FAIL sub_05_ovf got=%b want=0", rv); end
      run_op8(8'h80, 8'h01, 1'b1, rs, rc, rv, lat, bcnt);
      checks++; if (rs !== 8'h7F) begin failures++; $display("FAIL sub_80_s got=%h want=7f", rs); end
      checks++; if (rc !== 1'b1) begin failures++; $display("FAIL sub_80_c got=%b want=1", rc); end
      checks++; if (rv !== 1'b1) begin failures++; $display("FAIL sub_80_ovf got=%b want=1", rv); end
   endtask

   task automatic test_start_ignored();
      int lat;
      @(negedge clk);
      bus8.start = 1'b1;
      bus8.a = 8'h12;
      bus8.b = 8'h34;
      bus8.sub = 1'b0;
      @(negedge clk);
      bus8.start = 1'b0;
      lat = 0;
      while (!bus8.done && lat < 40) begin
         if (lat == 3) begin
            bus8.start = 1'b1;
            bus8.a = 8'h11;
            bus8.b = 8'h22;
            bus8.sub = 1'b1;
         end else begin
            bus8.start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      bus8.start = 1'b0;
      checks++; if (lat !== 8) begin failures++; $display("FAIL ignore_latency got=%0d want=8", lat); end
      checks++; if (bus8.s !== 8'h46) begin failures++; $display("FAIL ignore_s got=%h want=46", bus8.s); end
      checks++; if (bus8.c !== 1'b0 || bus8.ovf !== 1'b0) begin failures++; $display("FAIL ignore_c_ovf got=%b%b want=00", bus8.c, bus8.ovf); end
      @(negedge clk);
      checks++; if (bus8.busy !== 1'b0) begin failures++; $display("FAIL ignore_no_restart got=%b want=0", bus8.busy); end
   endtask

   task automatic test_reset_mid_run();
      logic [7:0] rs;
      logic       rc, rv;
      int         lat, bcnt, done_seen;
      run_op8(8'hFF, 8'h01, 1'b0, rs, rc, rv, lat, bcnt);
      @(negedge clk);
      bus8.start = 1'b1;
      bus8.a = 8'h33;
      bus8.b = 8'h44;
      bus8.sub = 1'b0;
      @(negedge clk);
      bus8.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin failures++; $display("FAIL midrst_ctrl got=%b%b want=00", bus8.busy, bus8.done); end
      checks++; if (bus8.s !== 8'h00) begin failures++; $display("FAIL midrst_s got=%h want=00", bus8.s); end
      checks++; if (bus8.c !== 1'b0 || bus8.ovf !== 1'b0) begin failures++; $display("FAIL midrst_c_ovf got=%b%b want=00", bus8.c, bus8.ovf); end
      done_seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus8.done || bus8.busy) done_seen++;
      end
      checks++; if (done_seen !== 0) begin failures++; $display("FAIL midrst_stays_idle got=%0d want=0", done_seen); end
      run_op8(8'h0A, 8'h05, 1'b0, rs, rc, rv, lat, bcnt);
      checks++; if (lat !== 8) begin failures++; $display("FAIL midrst_next_latency got=%0d want=8", lat); end
      checks++; if (rs !== 8'h0F || rc !== 1'b0 || rv !== 1'b0) begin failures++; $display("FAIL midrst_next got=%h/%b/%b want=0f/0/0", rs, rc, rv); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] oa [4] = '{8'h10, 8'h10, 8'hC0, 8'h7F};
      logic [7:0] ob [4] = '{8'h20, 8'h20, 8'h40, 8'h80};
      logic       om [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [7:0] es [4] = '{8'h30, 8'hF0, 8'h00, 8'hFF};
      logic       ec [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic       ev [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      int cnt;
      @(negedge clk);
      bus8.start = 1'b1;
      bus8.a = oa[0];
      bus8.b = ob[0];
      bus8.sub = om[0];
      @(negedge clk);
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         while (!bus8.done && cnt < 40) begin
            @(negedge clk);
            cnt++;
         end
         checks++; if (cnt !== ((i == 0) ? 8 : 9)) begin failures++; $display("FAIL b2b_interval_%0d got=%0d want=%0d", i, cnt, (i == 0) ? 8 : 9); end
         checks++; if (bus8.s !== es[i] || bus8.c !== ec[i] || bus8.ovf !== ev[i]) begin
            failures++; $display("FAIL b2b_result_%0d got=%h/%b/%b want=%h/%b/%b", i, bus8.s, bus8.c, bus8.ovf, es[i], ec[i], ev[i]);
         end
         if (i < 3) begin
            bus8.a = oa[i+1];
            bus8.b = ob[i+1];
            bus8.sub = om[i+1];
         end else begin
            bus8.start = 1'b0;
         end
         @(negedge clk);
         cnt = 1;
         checks++; if (bus8.busy !== (i < 3)) begin failures++; $display("FAIL b2b_busy_%0d got=%b want=%b", i, bus8.busy, (i < 3)); end
      end
   endtask

   task automatic test_width2();
      logic [1:0] ea, eb, bb, es;
      logic [2:0] sum;
      logic       ec, ev;
      int         lat;
      for (int k = 0; k < 32; k++) begin
         ea = 2'(k);
         eb = 2'(k >> 2);
         bb = k[4] ? ~eb : eb;
         sum = {1'b0, ea} + {1'b0, bb} + {2'b00, k[4]};
         es = sum[1:0];
         ec = sum[2];
         ev = (ea[1] == bb[1]) && (es[1] != ea[1]);
         @(negedge clk);
         bus2.start = 1'b1;
         bus2.a = ea;
         bus2.b = eb;
         bus2.sub = k[4];
         @(negedge clk);
         bus2.start = 1'b0;
         lat = 0;
         while (!bus2.done && lat < 20) begin
            @(negedge clk);
            lat++;
         end
         checks++; if (lat !== 2) begin failures++; $display("FAIL w2_latency_%0d got=%0d want=2", k, lat); end
         checks++; if (bus2.s !== es || bus2.c !== ec || bus2.ovf !== ev) begin
            failures++; $display("FAIL w2_result_%0d got=%h/%b/%b want=%h/%b/%b", k, bus2.s, bus2.c, bus2.ovf, es, ec, ev);
         end
      end
   endtask

   task automatic test_width16();
      logic [15:0] ea, eb, bb, es;
      logic [16:0] sum;
      logic        em, ec, ev;
      int          lat;
      for (int k = 0; k < 10; k++) begin
         case (k)
            0: begin ea = 16'hFFFF; eb = 16'h0001; em = 1'b0; end
            1: begin ea = 16'h8000; eb = 16'h0001; em = 1'b1; end
            2: begin ea = 16'h7FFF; eb = 16'h0001; em = 1'b0; end
            default: begin ea = 16'($urandom); eb = 16'($urandom); em = k[0]; end
         endcase
         bb = em ? ~eb : eb;
         sum = {1'b0, ea} + {1'b0, bb} + {16'h0000, em};
         es = sum[15:0];
         ec = sum[16];
         ev = (ea[15] == bb[15]) && (es[15] != ea[15]);
         @(negedge clk);
         bus16.start = 1'b1;
         bus16.a = ea;
         bus16.b = eb;
         bus16.sub = em;
         @(negedge clk);
         bus16.start = 1'b0;
         lat = 0;
         while (!bus16.done && lat < 40) begin
            @(negedge clk);
            lat++;
         end
         checks++; if (lat !== 16) begin failures++; $display("FAIL w16_latency_%0d got=%0d want=16", k, lat); end
         checks++; if (bus16.s !== es || bus16.c !== ec || bus16.ovf !== ev) begin
            failures++; $display("FAIL w16_result_%0d got=%h/%b/%b want=%h/%b/%b", k, bus16.s, bus16.c, bus16.ovf, es, ec, ev);
         end
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      bus8.start = 1'b0;  bus8.sub = 1'b0;  bus8.a = '0;  bus8.b = '0;
      bus2.start = 1'b0;  bus2.sub = 1'b0;  bus2.a = '0;  bus2.b = '0;
      bus16.start = 1'b0; bus16.sub = 1'b0; bus16.a = '0; bus16.b = '0;
      test_reset();
      test_add_basic();
      test_add_overflow();
      test_sub();
      test_start_ignored();
      test_reset_mid_run();
      test_back_to_back();
      test_width2();
      test_width16();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_adder_bm.md
# serial_adder_bm

Parametrised bit-serial adder/subtractor built around a single full-adder cell and a carry flip-flop. It is the sequential successor to the team's combinational half adder. Two WIDTH-bit operands are latched on a start request and processed one bit per clock, LSB first. The block then presents sum, carry/borrow and signed overflow with a one-cycle done pulse. Intended for area-constrained datapaths where one adder cell is time-shared over many bits.

## Interface
Parameters:
- WIDTH, 8, operand and sum width in bits; legal range WIDTH ≥ 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset, sampled on rising edge of clk.
- start  in  1  request; sampled only in IDLE or DONE.
- sub  in  1  mode at start: 0 = a+b, 1 = a−b; latched with the operands.
- a  in  WIDTH  operand A; latched at an accepted start.
- b  in  WIDTH  operand B; latched at an accepted start.
- busy  out  1  high while bits are being processed (RUN).
- done  out  1  one-cycle pulse; s/c/ovf valid from this cycle.
- s  out  WIDTH  sum/difference, registered.
- c  out  1  carry out; in subtract mode 1 = no borrow (a ≥ b unsigned).
- ovf  out  1  two's-complement overflow of the result.

## Operation
- Clock and reset: one clock, clk; reset is synchronous and active-high, port rst.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when start = 1.
  - RUN → DONE after WIDTH bit-steps.
  - DONE → RUN when start = 1, otherwise DONE → IDLE.
- Accepted start captures:
  - ra ← a;
  - rb ← b when sub = 0, or ~b when sub = 1;
  - cy ← sub;
  - bit counter ← 0;
  - s ← 0.
- RUN bit-step, each cycle:
  - sb = ra[0] ^ rb[0] ^ cy;
  - cy ← majority(ra[0], rb[0], cy);
  - ra and rb shift right by 1;
  - sb shifts into s at the MSB, with s shifting right;
  - counter increments.
- After WIDTH steps s holds the full result, LSB aligned.
- At the final step (counter = WIDTH−1):
  - ovf ← cy_in ^ cy_out;
  - c ← cy_out.
- The counter is $clog2(WIDTH) bits. It never exceeds WIDTH−1, so there is no wrap.
- Arithmetic is modulo 2^WIDTH. The carry out of the MSB goes to c only.
- start while in RUN is ignored; the operation in progress is unaffected.
- a, b and sub are don't-care except at an accepted start.
- s, c and ovf hold their values from DONE through IDLE until the next accepted start.
- Reset, including mid-RUN:
  - state → IDLE;
  - busy = 0, done = 0, s = 0, c = 0, ovf = 0;
  - internal ra, rb, cy and counter cleared;
  - any partial result is discarded.

## Timing
- Start accepted at rising edge k:
  - busy = 1 from after edge k through edge k+WIDTH;
  - edges k+1 … k+WIDTH perform bit-steps 0 … WIDTH−1.
- After edge k+WIDTH:
  - state DONE, busy = 0, done = 1;
  - s/c/ovf are valid.
  - Latency from the start edge to done is WIDTH cycles.
- After edge k+WIDTH+1: done = 0, unless a new start was accepted at that edge.
- Back-to-back operation:
  - start = 1 during DONE is accepted at edge k+WIDTH+1;
  - busy = 1 in the next cycle;
  - throughput is one result per WIDTH+1 cycles.
- rst = 1 and start = 1 at the same edge: reset wins.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, add, a=8'hFF, b=8'h01:
  - s=8'h00, c=1, ovf=0;
  - busy high for 8 cycles, then done high exactly 1 cycle, 8 edges after the start edge.
- Add, a=8'h7F, b=8'h01 → s=8'h80, c=0, ovf=1. Then a=8'h80, b=8'h80 → s=8'h00, c=1, ovf=1.
- Subtract, a=8'h05, b=8'h07 → s=8'hFE, c=0, ovf=0. Then a=8'h80, b=8'h01 → s=8'h7F, c=1, ovf=1.
- Start pulsed with a=8'h11, b=8'h22 at cycle 3 of RUN with different operands → ignored; the original result is returned at the original done cycle.
- rst asserted at cycle 4 of RUN → next cycle all outputs 0 and state IDLE. A following start with a=8'h0A, b=8'h05 yields s=8'h0F, c=0, ovf=0.
- Back-to-back: start held high continuously → done pulses every 9 cycles. Operands and mode are re-sampled on each DONE cycle, and s holds between pulses. Repeat the suite at WIDTH=2 and WIDTH=16 with random operands checked against a+b and a−b.
